// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM (R-type, I-type ALU, LW, SW, BEQ); optional macro ILLEGAL_TRAP_EN adds a HALT/trap state.
// Latency: 5 cycles R/I/SW, 6 cycles LW, 4 cycles BEQ, 3 cycles illegal NOP (zero-wait memories); outputs registered from next-state.
// Backpressure: waits in FETCH for instr_valid and in MEM for dmem_ack; both are ignored in every other state.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             Zero,
    input  logic             dmem_ack,
    output logic             ALUSrc,
    output logic [3:0]       ALUCtrl,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             PCSrc,
    output logic             loadPC,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             instr_req,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        PCUPD  = 3'd5
`ifdef ILLEGAL_TRAP_EN
        ,
        HALT   = 3'd6
`endif
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;
    logic       funct7b5_q;

    logic is_r, is_i, is_lw, is_sw, is_beq, is_legal;

    // Register/immediate fields are not needed by the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // ALU operation from the instruction fields. funct7b5 only selects the
    // alternate op for R-type and for SRAI, so ADDI with imm[10]=1 stays ADD.
    function automatic logic [3:0] alu_dec(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic       f7b5);
        logic [3:0] r;
        logic       alt;
        r   = ALU_AND;
        alt = (op == OP_R) ? f7b5 : ((op == OP_I) && (f3 == 3'b101) && f7b5);
        case (op)
            OP_R, OP_I: begin
                case (f3)
                    3'b000:  r = alt ? ALU_SUB : ALU_ADD;
                    3'b001:  r = ALU_SLL;
                    3'b010:  r = ALU_SLT;
                    3'b011:  r = ALU_SLT;
                    3'b100:  r = ALU_XOR;
                    3'b101:  r = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  r = ALU_OR;
                    default: r = ALU_AND;
                endcase
            end
            OP_LW, OP_SW: r = ALU_ADD;
            OP_BEQ:       r = ALU_SUB;
            default:      r = ALU_AND;
        endcase
        return r;
    endfunction

    // Instruction class from the latched opcode.
    always_comb begin
        is_r     = (opcode_q == OP_R);
        is_i     = (opcode_q == OP_I);
        is_lw    = (opcode_q == OP_LW);
        is_sw    = (opcode_q == OP_SW);
        is_beq   = (opcode_q == OP_BEQ);
        is_legal = is_r | is_i | is_lw | is_sw | is_beq;
    end

    // Next-state sequencing.
    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (instr_valid) next_state = DECODE;
            DECODE: begin
                if (is_legal) begin
                    next_state = EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    next_state = HALT;
`else
                    next_state = PCUPD;
`endif
                end
            end
            EXEC: begin
                if (is_r || is_i)        next_state = WB;
                else if (is_lw || is_sw) next_state = MEM;
                else                     next_state = PCUPD;
            end
            MEM:    if (dmem_ack) next_state = is_lw ? WB : PCUPD;
            WB:     next_state = PCUPD;
            PCUPD:  next_state = FETCH;
`ifdef ILLEGAL_TRAP_EN
            HALT:   next_state = HALT;
`endif
            default: next_state = FETCH;
        endcase
    end

    // State register plus decode-field latch; fields are captured on the
    // fetch-complete edge so they are stable for all of DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == FETCH && instr_valid) begin
                opcode_q   <= instr[6:0];
                funct3_q   <= instr[14:12];
                funct7b5_q <= instr[30];
            end
        end
    end

    // Moore outputs registered from next_state so each is glitch-free and
    // lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUSrc    <= 1'b0;
            ALUCtrl   <= '0;
            RegWrite  <= 1'b0;
            MemToReg  <= 1'b0;
            PCSrc     <= 1'b0;
            loadPC    <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            instr_req <= 1'b0;
            instret   <= '0;
        end else begin
            instr_req <= (next_state == FETCH);
            RegWrite  <= (next_state == WB);
            MemToReg  <= (next_state == WB) && is_lw;
            MemRead   <= (next_state == MEM) && is_lw;
            MemWrite  <= (next_state == MEM) && is_sw;
            loadPC    <= (next_state == PCUPD);

            // ALU controls live from DECODE until the instruction retires.
            if (state == FETCH && instr_valid) begin
                ALUCtrl <= alu_dec(instr[6:0], instr[14:12], instr[30]);
                ALUSrc  <= (instr[6:0] == OP_I) || (instr[6:0] == OP_LW) ||
                           (instr[6:0] == OP_SW);
            end else if (next_state != DECODE && next_state != EXEC &&
                         next_state != MEM && next_state != WB &&
                         next_state != PCUPD) begin
                ALUCtrl <= '0;
                ALUSrc  <= 1'b0;
            end

            // PCSrc is the registered branch outcome: Zero sampled in EXEC of
            // a BEQ, shown with loadPC and held through the following cycle.
            if (next_state == PCUPD)
                PCSrc <= (state == EXEC) && is_beq && Zero;
            else if (state != PCUPD)
                PCSrc <= 1'b0;

            if (next_state == PCUPD)
                instret <= instret + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky trap flag; only rst leaves HALT.
    always_ff @(posedge clk) begin
        if (rst) trap <= 1'b0;
        else     trap <= (next_state == HALT);
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instruction vectors plus hand sequences.
// Each instruction's expected record is queued when driven and popped when loadPC retires it.
// Memory handshakes are modelled with a programmable dmem_ack delay.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        Zero;
    logic        dmem_ack;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        RegWrite;
    logic        MemToReg;
    logic        PCSrc;
    logic        loadPC;
    logic        MemRead;
    logic        MemWrite;
    logic        instr_req;
    logic        trap;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .Zero(Zero), .dmem_ack(dmem_ack), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .PCSrc(PCSrc), .loadPC(loadPC),
        .MemRead(MemRead), .MemWrite(MemWrite), .instr_req(instr_req),
        .trap(trap), .instret(instret)
    );

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          ack_dly;
        logic        chk_alu;
        logic [3:0]  alu;
        logic        src;
        int          cycles;
        int          rw;
        logic        m2r;
        int          mr;
        int          mw;
        logic        pcsrc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   viol = 0;
    int   exp_instret = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic z, input int ack,
                                input logic ca, input logic [3:0] alu, input logic src,
                                input int cyc, input int rw, input logic m2r,
                                input int mr, input int mw, input logic pcs);
        vec_t v;
        v.instr = i; v.zero = z; v.ack_dly = ack; v.chk_alu = ca; v.alu = alu;
        v.src = src; v.cycles = cyc; v.rw = rw; v.m2r = m2r; v.mr = mr;
        v.mw = mw; v.pcsrc = pcs;
        return v;
    endfunction

    // Control-exclusivity watchdog over the whole run.
    always @(negedge clk) begin
        if (MemRead && MemWrite) viol++;
        if (RegWrite && MemWrite) viol++;
    end

    // Start in FETCH (at a negedge); drive one instruction and observe it to retirement.
    task automatic run(input vec_t v);
        int   cyc, rw, rw_at, mr, mw, memc;
        logic m2r, pcs, src_pc, done, src_e;
        logic [3:0] alu_e;
        vec_t e;
        exp_q.push_back(v);
        instr = v.instr; Zero = v.zero; instr_valid = 1'b1; dmem_ack = 1'b0;
        cyc = 1; rw = 0; rw_at = 0; mr = 0; mw = 0; memc = 0;
        m2r = 1'b0; pcs = 1'b0; src_pc = 1'b0; done = 1'b0; src_e = 1'b0; alu_e = '0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            instr_valid = 1'b0;
            if (cyc == 3) begin alu_e = ALUCtrl; src_e = ALUSrc; end
            if (RegWrite) begin rw++; rw_at = cyc; m2r = MemToReg; end
            if (MemRead) mr++;
            if (MemWrite) mw++;
            if (MemRead || MemWrite) begin
                memc++;
                dmem_ack = (memc >= v.ack_dly);
            end else begin
                dmem_ack = 1'b0;
            end
            if (loadPC) begin done = 1'b1; pcs = PCSrc; src_pc = ALUSrc; end
        end
        e = exp_q.pop_front();
        chk("retire_timeout", done, 1'b1);
        chk("latency", cyc, e.cycles);
        if (e.chk_alu) begin
            chk("alu_ctrl", alu_e, e.alu);
            chk("alu_src", src_e, e.src);
            chk("alu_src_held", src_pc, e.src);
        end
        chk("regwrite_cnt", rw, e.rw);
        if (e.rw > 0) chk("regwrite_cycle", rw_at, e.cycles - 1);
        chk("memtoreg", m2r, e.m2r);
        chk("memread_cnt", mr, e.mr);
        chk("memwrite_cnt", mw, e.mw);
        chk("pcsrc", pcs, e.pcsrc);
        chk("instret", instret, exp_instret + 1);
        exp_instret++;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("pcsrc_hold", PCSrc, e.pcsrc);
        chk("loadpc_1cyc", loadPC, 1'b0);
        chk("fetch_req", instr_req, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_valid = 1'b0; dmem_ack = 1'b0; Zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", {ALUSrc, ALUCtrl, RegWrite, MemToReg, PCSrc, loadPC,
                            MemRead, MemWrite, instr_req, trap}, 0);
        chk("rst_instret", instret, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", instr_req, 1'b1);
        chk("post_rst_loadpc", loadPC, 1'b0);
        exp_instret = 0;
    endtask

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0; Zero = 1'b0; dmem_ack = 1'b0;
        do_reset();

        //            instr         Z  ack chk alu    src cyc rw m2r mr mw pcs
        vecs.push_back(mk(32'h002081B3, 0, 1, 1, 4'b0010, 0, 5, 1, 0, 0, 0, 0)); // add
        vecs.push_back(mk(32'h402081B3, 0, 1, 1, 4'b0110, 0, 5, 1, 0, 0, 0, 0)); // sub
        vecs.push_back(mk(32'h0080A283, 0, 3, 1, 4'b0010, 1, 8, 1, 1, 3, 0, 0)); // lw slow
        vecs.push_back(mk(32'h0080A283, 0, 1, 1, 4'b0010, 1, 6, 1, 1, 1, 0, 0)); // lw fast
        vecs.push_back(mk(32'h0020A423, 0, 1, 1, 4'b0010, 1, 5, 0, 0, 0, 1, 0)); // sw
        vecs.push_back(mk(32'h0020A423, 0, 2, 1, 4'b0010, 1, 6, 0, 0, 0, 2, 0)); // sw wait
        vecs.push_back(mk(32'h00208463, 1, 1, 1, 4'b0110, 0, 4, 0, 0, 0, 0, 1)); // beq taken
        vecs.push_back(mk(32'h00208463, 0, 1, 1, 4'b0110, 0, 4, 0, 0, 0, 0, 0)); // beq not
        vecs.push_back(mk(32'h40225213, 0, 1, 1, 4'b1010, 1, 5, 1, 0, 0, 0, 0)); // srai
        vecs.push_back(mk(32'h40020213, 0, 1, 1, 4'b0010, 1, 5, 1, 0, 0, 0, 0)); // addi imm[10]
        vecs.push_back(mk(32'h0020C1B3, 0, 1, 1, 4'b1101, 0, 5, 1, 0, 0, 0, 0)); // xor
        vecs.push_back(mk(32'h0020D1B3, 0, 1, 1, 4'b1000, 0, 5, 1, 0, 0, 0, 0)); // srl
        vecs.push_back(mk(32'h4020D1B3, 0, 1, 1, 4'b1010, 0, 5, 1, 0, 0, 0, 0)); // sra
        vecs.push_back(mk(32'h00221213, 0, 1, 1, 4'b1001, 1, 5, 1, 0, 0, 0, 0)); // slli
        vecs.push_back(mk(32'h00222213, 0, 1, 1, 4'b0111, 1, 5, 1, 0, 0, 0, 0)); // slti
        vecs.push_back(mk(32'h00227213, 0, 1, 1, 4'b0000, 1, 5, 1, 0, 0, 0, 0)); // andi
        vecs.push_back(mk(32'h00226213, 0, 1, 1, 4'b0001, 1, 5, 1, 0, 0, 0, 0)); // ori
        vecs.push_back(mk(32'h40224213, 0, 1, 1, 4'b1101, 1, 5, 1, 0, 0, 0, 0)); // xori bit30
`ifndef ILLEGAL_TRAP_EN
        vecs.push_back(mk(32'h0000007F, 0, 1, 0, 4'b0000, 0, 3, 0, 0, 0, 0, 0)); // illegal NOP
`endif
        foreach (vecs[i]) run(vecs[i]);

        // Reset in the middle of a stalled SW.
        begin
            int n;
            logic seen;
            instr = 32'h0020A423; Zero = 1'b0; dmem_ack = 1'b0; instr_valid = 1'b1;
            n = 0; seen = 1'b0;
            while (!seen && n < 10) begin
                @(negedge clk);
                instr_valid = 1'b0;
                seen = MemWrite;
                n++;
            end
            chk("sw_mem_reached", seen, 1'b1);
            @(negedge clk);
            chk("sw_stall", MemWrite, 1'b1);
            chk("pre_rst_instret", instret, exp_instret);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_mid_memwrite", MemWrite, 1'b0);
            chk("rst_mid_loadpc", loadPC, 1'b0);
            chk("rst_mid_regwrite", RegWrite, 1'b0);
            chk("rst_mid_instret", instret, 0);
            rst = 1'b0;
            @(negedge clk);
            chk("after_rst_loadpc", loadPC, 1'b0);
            chk("after_rst_memwrite", MemWrite, 1'b0);
            chk("after_rst_fetch", instr_req, 1'b1);
            exp_instret = 0;
            run(vecs[0]);
        end

`ifdef ILLEGAL_TRAP_EN
        // Illegal opcode halts: trap from cycle 3, sticky, nothing retires.
        begin
            int tcnt, lpc, base;
            base = exp_instret;
            instr = 32'h0000007F; instr_valid = 1'b1; tcnt = 0; lpc = 0;
            for (int c = 2; c <= 22; c++) begin
                @(negedge clk);
                instr_valid = 1'b0;
                if (c == 3) chk("trap_cycle3", trap, 1'b1);
                if (trap) tcnt++;
                if (loadPC) lpc++;
            end
            chk("trap_held", tcnt, 20);
            chk("trap_no_loadpc", lpc, 0);
            chk("trap_instret", instret, base);
            chk("trap_ctrl_zero", {ALUSrc, ALUCtrl, RegWrite, MemRead, MemWrite, instr_req}, 0);
            do_reset();
            chk("trap_cleared", trap, 1'b0);
        end
`endif

        chk("exclusive_ctrl", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
